// File: rtl/rx_block_sync.sv
`default_nettype none
// ============================================================================
//  Module   : rx_block_sync
//  Purpose  : 64b/66b receive block-lock controller. Watches the 2-bit sync
//             header of each gearbox word, requests bitslips until headers
//             align, then declares and maintains block lock using windowed
//             valid/invalid header counting.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             data_valid          - gearbox word valid this cycle
//             sync_info[1:0]      - sync header (01/10 valid, 00/11 invalid)
//             bitslip             - registered one-cycle slip request
//             block_lock          - registered block lock indication
//             desc_enable         - descrambler enable (follows data_valid)
//             data_valid_out      - registered data_valid & block_lock
//             slip_count[7:0]     - saturating count of slips issued
//             error_count[7:0]    - saturating count of invalid headers
//                                   seen while locked
//  Revision : 1.0 - initial release
// ============================================================================
module rx_block_sync #(
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [1:0] sync_info,
    output logic       bitslip,
    output logic       block_lock,
    output logic       desc_enable,
    output logic       data_valid_out,
    output logic [7:0] slip_count,
    output logic [7:0] error_count
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    // Terminal values are compared against the pre-increment count so the
    // decision is taken on the same word that reaches the limit.
    localparam logic [CNT_W-1:0]  c_SH_CNT_LAST = CNT_W'(SH_CNT_MAX - 1);
    localparam logic [INV_W-1:0]  c_SH_INV_LAST = INV_W'(SH_INVALID_MAX - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST   = WAIT_W'(SLIP_WAIT - 1);

    localparam logic [1:0] c_RESET_CNT    = 2'd0;
    localparam logic [1:0] c_TEST_SH      = 2'd1;
    localparam logic [1:0] c_SLIP_WAIT_ST = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_sh_cnt;
    logic [CNT_W-1:0]  w_sh_cnt_nxt;
    logic [INV_W-1:0]  r_sh_inv;
    logic [INV_W-1:0]  w_sh_inv_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_bitslip;
    logic              w_bitslip_nxt;
    logic              r_block_lock;
    logic              w_block_lock_nxt;
    logic              r_data_valid_out;
    logic [7:0]        r_slip_count;
    logic [7:0]        w_slip_count_nxt;
    logic [7:0]        r_error_count;
    logic [7:0]        w_error_count_nxt;

    logic w_hdr_valid;
    logic w_eval;
    logic w_slip_unlocked;
    logic w_lose_lock;
    logic w_slip;
    logic w_window_done;
    logic w_wait_done;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Exactly one header bit set means a valid 01/10 sync header.
    assign w_hdr_valid     = sync_info[1] ^ sync_info[0];
    assign w_eval          = (r_state == c_TEST_SH) && data_valid;
    assign w_slip_unlocked = w_eval && !r_block_lock && !w_hdr_valid;
    // Loss of lock takes priority over the window-complete decision.
    assign w_lose_lock     = w_eval && r_block_lock && !w_hdr_valid &&
                             (r_sh_inv == c_SH_INV_LAST);
    assign w_slip          = w_slip_unlocked || w_lose_lock;
    assign w_window_done   = w_eval && (r_sh_cnt == c_SH_CNT_LAST);
    assign w_wait_done     = (r_state == c_SLIP_WAIT_ST) && (r_wait_cnt == c_WAIT_LAST);

    // ------------------------------------------------------------------
    // State register (also holds all counters and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_RESET_CNT;
            r_sh_cnt         <= '0;
            r_sh_inv         <= '0;
            r_wait_cnt       <= '0;
            r_bitslip        <= 1'b0;
            r_block_lock     <= 1'b0;
            r_data_valid_out <= 1'b0;
            r_slip_count     <= 8'd0;
            r_error_count    <= 8'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_sh_cnt         <= w_sh_cnt_nxt;
            r_sh_inv         <= w_sh_inv_nxt;
            r_wait_cnt       <= w_wait_cnt_nxt;
            r_bitslip        <= w_bitslip_nxt;
            r_block_lock     <= w_block_lock_nxt;
            r_data_valid_out <= data_valid && r_block_lock;
            r_slip_count     <= w_slip_count_nxt;
            r_error_count    <= w_error_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RESET_CNT:    w_state_nxt = c_TEST_SH;
            c_TEST_SH:      if (w_slip) w_state_nxt = c_SLIP_WAIT_ST;
            c_SLIP_WAIT_ST: if (w_wait_done) w_state_nxt = c_RESET_CNT;
            default:        w_state_nxt = c_RESET_CNT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_sh_cnt_nxt      = r_sh_cnt;
        w_sh_inv_nxt      = r_sh_inv;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_block_lock_nxt  = r_block_lock;
        // A slip is only ever decided in TEST_SH, so the pulse is one cycle
        // wide and lands on the first cycle of the wait state.
        w_bitslip_nxt     = w_slip;
        w_slip_count_nxt  = r_slip_count;
        w_error_count_nxt = r_error_count;
        case (r_state)
            c_RESET_CNT: begin
                w_sh_cnt_nxt   = '0;
                w_sh_inv_nxt   = '0;
                w_wait_cnt_nxt = '0;
            end
            c_TEST_SH: begin
                if (data_valid) begin
                    if (w_slip) begin
                        w_block_lock_nxt = 1'b0;
                        w_wait_cnt_nxt   = '0;
                        w_slip_count_nxt = sat_inc(r_slip_count);
                    end else if (w_window_done) begin
                        // Window restarts in place; no RESET_CNT dead cycle.
                        w_sh_cnt_nxt     = '0;
                        w_sh_inv_nxt     = '0;
                        w_block_lock_nxt = 1'b1;
                    end else begin
                        w_sh_cnt_nxt = r_sh_cnt + 1'b1;
                        if (r_block_lock && !w_hdr_valid)
                            w_sh_inv_nxt = r_sh_inv + 1'b1;
                    end
                    if (r_block_lock && !w_hdr_valid)
                        w_error_count_nxt = sat_inc(r_error_count);
                end
            end
            c_SLIP_WAIT_ST: begin
                // Counts clk cycles; data_valid and headers are ignored here.
                w_wait_cnt_nxt = w_wait_done ? '0 : r_wait_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    assign bitslip        = r_bitslip;
    assign block_lock     = r_block_lock;
    assign desc_enable    = data_valid;
    assign data_valid_out = r_data_valid_out;
    assign slip_count     = r_slip_count;
    assign error_count    = r_error_count;

endmodule
`default_nettype wire
